// File: rtl/l1_dcache_responder.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the LC-3b memory stage.
// Zero-cycle hits. Misses go out over a 128-bit line port and may write back a dirty victim first.
module l1_dcache_responder #(
    parameter int NUM_SETS = 8,
    parameter int TAG_W    = 12 - $clog2(NUM_SETS)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int IW = $clog2(NUM_SETS);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t state, state_nxt;

    logic [NUM_SETS-1:0] valid;
    logic [NUM_SETS-1:0] dirty;
    logic [TAG_W-1:0]    tag_arr  [NUM_SETS];
    logic [127:0]        data_arr [NUM_SETS];

    // Miss target is captured so a dropped or changed CPU request cannot redirect a fill.
    logic [IW-1:0]    miss_idx;
    logic [TAG_W-1:0] miss_tag;

    logic [IW-1:0]    idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       word;
    logic [127:0]     line;
    logic [15:0]      sel_word;
    logic             req;
    logic             hit;
    logic             hit_wr;
    logic             wb_done;
    logic             fill_done;
    logic             miss_start;
    logic             unused_addr_bit;

    assign idx             = mem_address[3+IW:4];
    assign req_tag         = mem_address[15:4+IW];
    assign word            = mem_address[3:1];
    assign unused_addr_bit = mem_address[0];
    assign req             = mem_read | mem_write;
    assign line            = data_arr[idx];
    assign sel_word        = line[{word, 4'b0000} +: 16];
    assign hit             = valid[idx] && (tag_arr[idx] == req_tag);
    assign mem_rdata       = reset_n ? sel_word : 16'h0000;

    always_comb begin
        state_nxt    = state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = '0;
        hit_wr       = 1'b0;
        wb_done      = 1'b0;
        fill_done    = 1'b0;
        miss_start   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        hit_wr   = mem_write;
                    end else begin
                        miss_start = 1'b1;
                        state_nxt  = (valid[idx] && dirty[idx]) ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[miss_idx], miss_idx, 4'b0000};
                pmem_wdata   = data_arr[miss_idx];
                if (pmem_resp) begin
                    wb_done   = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag, miss_idx, 4'b0000};
                if (pmem_resp) begin
                    fill_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            valid    <= '0;
            dirty    <= '0;
            miss_idx <= '0;
            miss_tag <= '0;
        end else begin
            state <= state_nxt;
            if (miss_start) begin
                miss_idx <= idx;
                miss_tag <= req_tag;
            end
            // A write with no byte enables still marks the line dirty.
            if (hit_wr)
                dirty[idx] <= 1'b1;
            if (wb_done)
                dirty[miss_idx] <= 1'b0;
            if (fill_done) begin
                valid[miss_idx] <= 1'b1;
                dirty[miss_idx] <= 1'b0;
            end
        end
    end

    // Data and tag storage is intentionally left unreset; valid bits qualify it.
    always_ff @(posedge clk) begin
        if (hit_wr) begin
            if (mem_byte_enable[0])
                data_arr[idx][{word, 4'b0000} +: 8] <= mem_wdata[7:0];
            if (mem_byte_enable[1])
                data_arr[idx][{word, 4'b1000} +: 8] <= mem_wdata[15:8];
        end
        if (fill_done) begin
            data_arr[miss_idx] <= pmem_rdata;
            tag_arr[miss_idx]  <= miss_tag;
        end
    end
endmodule

// File: tb/tb_l1_dcache_responder.sv
// Directed bench for l1_dcache_responder: scoreboard queues for CPU and line-port traffic, plus a latency-3 memory model.
module tb_l1_dcache_responder;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [1:0]   mem_byte_enable = 2'b00;
    logic [15:0]  mem_address = 16'h0000;
    logic [15:0]  mem_wdata = 16'h0000;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    l1_dcache_responder #(.NUM_SETS(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {bit rd; logic [15:0] data;} cpu_exp_t;
    typedef struct {bit wr; logic [15:0] addr; logic [15:0] w2;} pm_exp_t;

    cpu_exp_t cpu_q[$];
    pm_exp_t  pm_q[$];
    logic [127:0] mem_model [logic [15:0]];
    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Line-port responder: answers any request after 3 cycles with a one-cycle pmem_resp.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                cnt = 0;
            end else if (reset_n && (pmem_read || pmem_write)) begin
                cnt++;
                if (cnt >= 3) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) mem_model[pmem_address] = pmem_wdata;
                    else pmem_rdata = mem_model.exists(pmem_address) ? mem_model[pmem_address] : '0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes a transaction.
    always @(negedge clk) begin
        cpu_exp_t ce;
        pm_exp_t  pe;
        if (mem_resp) begin
            checks++;
            if (cpu_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_mem_resp addr=%0h", mem_address);
            end else begin
                ce = cpu_q.pop_front();
                if (ce.rd) chk("mem_rdata", {112'h0, mem_rdata}, {112'h0, ce.data});
            end
        end
        if (pmem_read || pmem_write) begin
            checks++;
            if (pmem_read && pmem_write) begin
                failures++;
                $display("FAIL pmem_exclusive read=1 write=1 required one");
            end else if (pm_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pmem read=%0b write=%0b addr=%0h", pmem_read, pmem_write, pmem_address);
            end
        end
        if (pmem_resp && (pmem_read || pmem_write) && pm_q.size() > 0) begin
            pe = pm_q.pop_front();
            chk("pmem_kind_is_write", {127'h0, pmem_write}, {127'h0, pe.wr});
            chk("pmem_address", {112'h0, pmem_address}, {112'h0, pe.addr});
            if (pe.wr) chk("pmem_wdata_word2", {112'h0, pmem_wdata[47:32]}, {112'h0, pe.w2});
        end
    end

    task automatic access(bit rd, bit wr, logic [1:0] be, logic [15:0] a, logic [15:0] wd,
                          logic [15:0] exp, int exp_lat);
        int lat;
        bit got;
        cpu_q.push_back('{rd && !wr, exp});
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_address = a; mem_wdata = wd;
        lat = 0; got = 0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (mem_resp) got = 1;
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        if (!got) begin
            chk("access_timeout", 128'h0, 128'h1);
            void'(cpu_q.pop_back());
        end else if (exp_lat > 0) begin
            chk("latency", lat, exp_lat);
        end
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog time limit reached");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        mem_model[16'h1230] = 128'h7777_6666_5555_4444_3333_BEEF_1111_0000;
        mem_model[16'h5230] = 128'hF7F7_F6F6_F5F5_F4F4_F3F3_F2F2_F1F1_F0F0;
        mem_model[16'h9230] = 128'h9797_9696_9595_9494_9393_9292_9191_9090;
        mem_model[16'hA230] = 128'hA7A7_A6A6_A5A5_A4A4_A3A3_A2A2_A1A1_A0A0;

        #12;
        chk("rst_mem_resp", {127'h0, mem_resp}, 128'h0);
        chk("rst_pmem_read", {127'h0, pmem_read}, 128'h0);
        chk("rst_pmem_write", {127'h0, pmem_write}, 128'h0);
        chk("rst_pmem_address", {112'h0, pmem_address}, 128'h0);
        chk("rst_pmem_wdata", pmem_wdata, 128'h0);
        chk("rst_mem_rdata", {112'h0, mem_rdata}, 128'h0);
        @(negedge clk); reset_n = 1'b1;

        // Cold read miss: fill only, 5-cycle latency.
        pm_q.push_back('{1'b0, 16'h1230, 16'h0});
        access(1, 0, 2'b00, 16'h1234, 16'h0, 16'hBEEF, 5);
        // Low-byte write hit, then read back.
        access(0, 1, 2'b01, 16'h1234, 16'h00AA, 16'h0, 1);
        access(1, 0, 2'b00, 16'h1234, 16'h0, 16'hBEAA, 1);
        // Dirty conflict miss: writeback then fill.
        pm_q.push_back('{1'b1, 16'h1230, 16'hBEAA});
        pm_q.push_back('{1'b0, 16'h5230, 16'h0});
        access(1, 0, 2'b00, 16'h5234, 16'h0, 16'hF2F2, 0);
        // Clean conflict miss: fill only.
        pm_q.push_back('{1'b0, 16'h9230, 16'h0});
        access(1, 0, 2'b00, 16'h9234, 16'h0, 16'h9292, 5);
        // Read+write together acts as a high-byte write.
        access(1, 1, 2'b10, 16'h9234, 16'h7700, 16'h0, 1);
        access(1, 0, 2'b00, 16'h9234, 16'h0, 16'h7792, 1);
        // Dirty data reaches memory; the earlier writeback supplies the refill.
        pm_q.push_back('{1'b1, 16'h9230, 16'h7792});
        pm_q.push_back('{1'b0, 16'h1230, 16'h0});
        access(1, 0, 2'b00, 16'h1234, 16'h0, 16'hBEAA, 0);

        // Reset pulsed while a fill is outstanding.
        pm_q.push_back('{1'b0, 16'hA230, 16'h0});
        @(posedge clk); #1;
        mem_read = 1'b1; mem_address = 16'hA238;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pmem_read && n < 20);
        chk("fill_started", {127'h0, pmem_read}, 128'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_fill_pmem_read", {127'h0, pmem_read}, 128'h0);
        chk("rst_mid_fill_pmem_address", {112'h0, pmem_address}, 128'h0);
        mem_read = 1'b0;
        void'(pm_q.pop_front());
        @(posedge clk); #1;
        @(negedge clk); reset_n = 1'b1;
        pm_q.push_back('{1'b0, 16'hA230, 16'h0});
        access(1, 0, 2'b00, 16'hA238, 16'h0, 16'hA4A4, 5);

        repeat (3) @(posedge clk);
        chk("cpu_queue_drained", cpu_q.size(), 0);
        chk("pmem_queue_drained", pm_q.size(), 0);
        summary();
        $finish;
    end
endmodule

// File: doc/l1_dcache_responder.md
# l1_dcache_responder

Direct-mapped, write-back, write-allocate data cache that serves as the responder for the pipelined LC-3b datapath's data-memory port. It answers 16-bit CPU reads and writes with byte enables. On a miss it drives a 128-bit line-wide request/response port toward physical memory or an arbiter. It sits between the datapath's MAR/MDR memory stage and the memory system.

## Interface
Parameters:
- NUM_SETS, 8, number of lines; power of two, 2..64; index width IW = log2(NUM_SETS)
- TAG_W, 12 - IW, tag width (address bits [15:4+IW])

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_byte_enable  in  2  [1]=high byte, [0]=low byte; used on writes only
- mem_address  in  16  byte address; bit 0 ignored for word select
- mem_wdata  in  16  write data
- mem_rdata  out  16  read data; valid when mem_resp=1 for a read
- mem_resp  out  1  one-cycle completion strobe
- pmem_read  out  1  line fill request; held until pmem_resp
- pmem_write  out  1  line writeback request; held until pmem_resp
- pmem_address  out  16  line-aligned address ([3:0]=0)
- pmem_wdata  out  128  victim line data
- pmem_rdata  in  128  fill line data; valid with pmem_resp
- pmem_resp  in  1  physical memory completion strobe

## Operation
- Address split: offset = addr[3:0], word = addr[3:1], index = addr[3+IW:4], tag = addr[15:4+IW].
- Storage per set: valid, dirty, tag, 128-bit data (word w = data[16w+15:16w]). Tag/valid/dirty/data are flop arrays; compare is combinational.
- hit = valid[index] && tag[index]==tag.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE, no request: outputs idle.
- IDLE, request and hit: mem_resp=1 in the same cycle.
  - Read: mem_rdata = selected word.
  - Write: each enabled byte of the selected word updates at the clock edge; dirty[index] is set. mem_byte_enable=2'b00 on a write still responds, updates no data, and still sets dirty.
- IDLE, request and miss:
  - If valid && dirty, go to WRITEBACK.
  - Otherwise go to FILL.
  - No mem_resp is given.
- WRITEBACK:
  - pmem_write=1.
  - pmem_address = {stored tag, index, 4'b0}.
  - pmem_wdata = stored line.
  - On pmem_resp, clear dirty and go to FILL.
- FILL:
  - pmem_read=1.
  - pmem_address = {request tag, index, 4'b0}.
  - On pmem_resp, load pmem_rdata, write tag, set valid, clear dirty, and go to IDLE.
  - The re-presented request then hits.
- mem_read and mem_write both high is treated as a write.
- pmem_read and pmem_write are never high together.
- pmem_resp outside WRITEBACK/FILL is ignored.
- If the CPU drops a request mid-miss, the miss sequence still completes, no mem_resp is issued, and the line is installed.
- mem_rdata when not responding to a read: selected word of the indexed line (don't-care to the CPU, but deterministic).

## Timing
- Reset (asynchronous, reset_n=0):
  - State = IDLE; all valid and dirty bits = 0.
  - mem_resp, pmem_read, pmem_write = 0.
  - pmem_address = 0, pmem_wdata = 0, mem_rdata = 0 during reset.
  - Data and tag arrays are not reset.
- Reset asserted mid-miss: pmem strobes drop immediately. A partially completed sequence leaves the line invalid if FILL never completed. A completed WRITEBACK is not repeated.
- Hit latency: 0 cycles (mem_resp combinational in the request cycle); write data commits at that edge.
- Clean miss: 1 cycle (IDLE→FILL) + N_fill cycles until pmem_resp + 1 cycle (hit in IDLE).
- Dirty miss adds the WRITEBACK duration.
- mem_resp is high exactly one cycle per completed request. The CPU must deassert or change the request the following cycle; a held request is served again as a new hit.
- pmem_resp is sampled only at the rising edge; a single-cycle pmem_resp advances the FSM exactly once.

## Test plan
- Reset, then read 0x1234 (pmem_resp after 3 cycles, fill data word2=0xBEEF):
  - pmem_read=1 with pmem_address=0x1230.
  - Next IDLE cycle gives mem_resp=1 and mem_rdata=0xBEEF.
  - Total latency = 5 cycles.
- Write 0x1234 with byte_enable=2'b01, wdata=0x00AA (hit): mem_resp in the same cycle; a subsequent read returns 0xBEAA; no pmem activity.
- Read 0x5234 (same index, different tag, line dirty):
  - pmem_write=1, pmem_address=0x1230, pmem_wdata word2=0xBEAA.
  - Then pmem_read at 0x5230, then mem_resp.
  - pmem_read and pmem_write are never high together.
- Clean conflict miss: only a FILL occurs; no pmem_write.
- reset_n pulsed low during FILL:
  - pmem_read drops immediately.
  - After release, a read to the same address misses again (valid=0).
- mem_read and mem_write high together with byte_enable=2'b10, wdata=0x7700 on a hit: treated as a write; the high byte updates; dirty is set (observed via later writeback data).
